// File: rtl/writeback_unit_pkg.sv
// Shared types and constants for the writeback unit and its result FIFO.
// The optional bypass path is enabled by defining WB_BYPASS_EN.
package writeback_unit_pkg;

    localparam logic [4:0] ZERO_REG = 5'd31;
    localparam int         WB_DEPTH = 2;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [63:0] data;
    } wb_entry_t;

    // A queued entry blocks a reader of q only if it will really write q.
    function automatic logic entry_match(input wb_entry_t e, input logic vld,
                                         input logic [4:0] q);
        return vld && e.we && (e.rd == q) && (q != ZERO_REG);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Two-entry result FIFO: storage, wrapping pointers, occupancy count, full/empty.
// Exposes the oldest (head) and youngest entries for write-port and bypass use.
module wb_fifo
    import writeback_unit_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t push_entry,
    output wb_entry_t head_entry,
    output wb_entry_t young_entry,
    output logic      full,
    output logic      empty
);

    localparam logic [1:0] FULL_CNT = 2'(WB_DEPTH);

    wb_entry_t  mem [WB_DEPTH];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;

    assign full        = (count == FULL_CNT);
    assign empty       = (count == 2'd0);
    assign head_entry  = mem[rd_ptr];
    // Only meaningful when full: the second entry then sits opposite the head.
    assign young_entry = mem[~rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: buffers MEM results in a 2-entry FIFO, drives the regfile
// write port from the head, and answers hazard/bypass queries. Bypass muxes are
// built only when WB_BYPASS_EN is defined.
module writeback_unit
    import writeback_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_regwrite,
    input  logic [4:0]  in_rd,
    input  logic [63:0] in_data,
    input  logic        wr_hold,
    output logic        RegWrite,
    output logic [4:0]  WriteRegister,
    output logic [63:0] WriteData,
    input  logic [4:0]  q_reg1,
    input  logic [4:0]  q_reg2,
    output logic        busy1,
    output logic        busy2,
    output logic        byp_hit1,
    output logic        byp_hit2,
    output logic [63:0] byp_data1,
    output logic [63:0] byp_data2
);

    // Handshake: a result is taken on a rising edge when in_valid && in_ready;
    // a full FIFO still accepts when its head retires in the same cycle.
    logic      push;
    logic      pop;
    logic      full;
    logic      empty;
    wb_entry_t in_entry;
    wb_entry_t head;
    wb_entry_t young;

    assign pop      = !empty && !wr_hold;
    assign in_ready = !full || pop;
    assign push     = in_valid && in_ready;
    assign in_entry = '{we: in_regwrite, rd: in_rd, data: in_data};

    wb_fifo u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .pop         (pop),
        .push_entry  (in_entry),
        .head_entry  (head),
        .young_entry (young),
        .full        (full),
        .empty       (empty)
    );

    assign RegWrite      = pop && head.we && (head.rd != ZERO_REG);
    assign WriteRegister = empty ? 5'd0  : head.rd;
    assign WriteData     = empty ? 64'd0 : head.data;

    logic m1_old, m1_young, m2_old, m2_young;

    assign m1_old   = entry_match(head,  !empty, q_reg1);
    assign m1_young = entry_match(young, full,   q_reg1);
    assign m2_old   = entry_match(head,  !empty, q_reg2);
    assign m2_young = entry_match(young, full,   q_reg2);

    assign busy1 = m1_old || m1_young;
    assign busy2 = m2_old || m2_young;

`ifdef WB_BYPASS_EN
    // The youngest matching entry is the value the register will finally hold.
    assign byp_hit1  = busy1;
    assign byp_hit2  = busy2;
    assign byp_data1 = m1_young ? young.data : (m1_old ? head.data : 64'd0);
    assign byp_data2 = m2_young ? young.data : (m2_old ? head.data : 64'd0);
`else
    logic unused_young_data;
    assign unused_young_data = ^young.data;
    assign byp_hit1  = 1'b0;
    assign byp_hit2  = 1'b0;
    assign byp_data1 = 64'd0;
    assign byp_data2 = 64'd0;
`endif

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The interface SHALL have exactly one clock and exactly one reset; clk and reset SHALL be listed first.
- clk  input  1  sole clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
REQ-002 in_valid  input  1  result from MEM stage present.
REQ-003 in_ready  output  1  unit accepts the result this cycle.
REQ-004 in_regwrite  input  1  the result updates a register; 0 means consume and discard.
REQ-005 in_rd  input  5  destination register number.
REQ-006 in_data  input  64  result value.
REQ-007 wr_hold  input  1  the regfile write port is unavailable this cycle.
REQ-008 RegWrite  output  1  regfile write enable.
REQ-009 WriteRegister  output  5  regfile write selector.
REQ-010 WriteData  output  64  regfile write data.
REQ-011 q_reg1, q_reg2  input  5 each  hazard/bypass query registers.
REQ-012 busy1, busy2  output  1 each  a queued write targets q_reg1/q_reg2.
REQ-013 byp_hit1, byp_hit2  output  1 each  bypass data is valid.
REQ-014 byp_data1, byp_data2  output  64 each  bypass values.

Function
REQ-015 The unit SHALL hold a 2-entry FIFO; each entry SHALL store {we, rd, data}.
REQ-016 Acceptance SHALL occur on a rising edge with in_valid && in_ready.
REQ-017 in_ready SHALL equal !full || pop, so a push and a pop on a full FIFO in the same cycle SHALL be legal.
REQ-018 pop SHALL equal !empty && !wr_hold.
REQ-019 The write port SHALL be driven combinationally from the FIFO head.
REQ-020 RegWrite SHALL equal pop && head.we && (head.rd != 31).
REQ-021 WriteRegister and WriteData SHALL equal head.rd and head.data, and SHALL be 0 when the FIFO is empty.
REQ-022 Latency: a result accepted at edge N SHALL appear on the write port in cycle N+1 if the FIFO was empty or popping, else once it reaches the head.
REQ-023 Entries with rd = 31 or we = 0 SHALL be accepted and popped normally and SHALL never assert RegWrite.
REQ-024 busyK SHALL be 1 iff any valid entry has we = 1, rd = q_regK, and q_regK != 31.
REQ-025 Bypass: byp_hitK SHALL be 1 iff busyK = 1, and byp_dataK SHALL come from the youngest matching entry.
REQ-026 Bypass: byp_dataK SHALL be 0 whenever byp_hitK = 0.
REQ-027 Bypass SHALL cover stored entries only, not the same-cycle input.
REQ-028 Ordering SHALL be strict FIFO; writes to the same rd SHALL retire in arrival order.
REQ-029 Pointers SHALL wrap modulo 2; the count SHALL range over 0..2 and never overflow or underflow.
REQ-030 A push while full with no pop SHALL be impossible by construction, because in_ready = 0 in that case.

Reset
REQ-031 When reset is asserted, asynchronously: FIFO empty, pointers and count 0, and all entry fields 0.
REQ-032 While reset is asserted, outputs SHALL be: in_ready = 1, RegWrite = 0, WriteRegister = 0, WriteData = 0, busy = 0, byp_hit = 0, byp_data = 0.
REQ-033 Reset mid-operation SHALL discard queued writes with no partial write issued.

Configuration
REQ-034 With WB_BYPASS_EN defined, byp_hit1/2 and byp_data1/2 SHALL behave as specified in REQ-025 to REQ-027.
REQ-035 Without WB_BYPASS_EN, the ports SHALL remain present, tied to 0, with no bypass mux logic synthesized.
REQ-036 busy1/busy2 SHALL be unaffected by WB_BYPASS_EN.

Structure
REQ-037 A shared package SHALL hold the entry struct {we, rd[4:0], data[63:0]}, the constant ZERO_REG = 31, and the constant WB_DEPTH = 2.
REQ-038 One sub-module, wb_fifo (storage, pointers, count, full/empty), SHALL be instantiated.
REQ-039 The match and bypass logic SHALL reside in writeback_unit.

Verification
REQ-040 Single write: push rd = 5, data = 0xDEAD_BEEF, we = 1 -> next cycle RegWrite = 1, WriteRegister = 5, WriteData = 0xDEADBEEF; FIFO then empty.
REQ-041 X31 suppression: push rd = 31, we = 1 -> entry popped with RegWrite = 0; busy = 0 for q_reg = 31.
REQ-042 Hold and full: wr_hold = 1, push rd = 1 then rd = 2 -> in_ready = 0 with no third acceptance; release wr_hold -> writes rd = 1 then rd = 2 on consecutive cycles.
REQ-043 Youngest bypass: wr_hold = 1, push rd = 3 data = 0x11 then rd = 3 data = 0x22; q_reg1 = 3 -> busy1 = 1, byp_hit1 = 1, byp_data1 = 0x22 (0 without WB_BYPASS_EN).
REQ-044 Full push/pop: FIFO full, wr_hold = 0, in_valid = 1 -> in_ready = 1; count stays 2 and order is preserved.
REQ-045 Reset mid-queue: two entries held, assert reset -> RegWrite = 0, busy = 0, in_ready = 1 immediately, with no write issued after release.
